// File: rtl/r2r_adc_scheduler_if.sv
// Requester/ladder bundle for the shared R-2R ramp-compare ADC scheduler.
// The scheduler takes the slave side; requesters and comparator pins sit on the master side.
interface r2r_adc_scheduler_if #(
    parameter int WIDTH = 8,
    parameter int N_REQ = 2
);
    logic             enable;
    logic [N_REQ-1:0] req;
    logic             vcompare_raw;
    logic [N_REQ-1:0] grant;
    logic             busy;
    logic [WIDTH-1:0] r2r_out;
    logic [N_REQ-1:0] done;
    logic [WIDTH-1:0] result_code;
    logic [15:0]      result_mV;
    logic             under_range;
    logic             over_range;

    modport master (
        output enable, req, vcompare_raw,
        input  grant, busy, r2r_out, done, result_code, result_mV, under_range, over_range
    );

    modport slave (
        input  enable, req, vcompare_raw,
        output grant, busy, r2r_out, done, result_code, result_mV, under_range, over_range
    );
endinterface

// File: rtl/r2r_adc_scheduler.sv
// Round-robin scheduler sharing one R-2R ladder and comparator among N_REQ requesters.
// Each grant runs settle -> ramp -> capture and returns the code and a millivolt value.
module r2r_adc_scheduler #(
    parameter int WIDTH       = 8,
    parameter int N_REQ       = 2,
    parameter int STEP_CYCLES = 256,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    r2r_adc_scheduler_if.slave  bus
);
    localparam int LG_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W  = $clog2(STEP_CYCLES) + 1;
    localparam int PROD_W = WIDTH + 12;
    localparam logic [WIDTH-1:0] CODE_MAX  = {WIDTH{1'b1}};
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RAMP   = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic logic [15:0] code_to_mv(input logic [WIDTH-1:0] code);
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(code) * PROD_W'(32'd3300);
        return 16'(prod >> WIDTH);
    endfunction

    state_t            state_r, state_s;
    logic [SYNC_STAGES-1:0] sync_r;
    logic [WIDTH-1:0]  code_pipe_r [SYNC_STAGES];
    logic              comp_sync_s;
    logic [WIDTH-1:0]  tag_code_s;
    logic              edge_s;

    logic [CNT_W-1:0]  step_cnt_r, step_cnt_s;
    logic              prev_r, prev_s;
    logic [LG_W-1:0]   last_granted_r, last_granted_s;
    logic [LG_W-1:0]   grant_idx_r, grant_idx_s;
    logic [LG_W-1:0]   pick_idx_s;
    logic [N_REQ-1:0]  grant_r, grant_s;
    logic              busy_r, busy_s;
    logic [WIDTH-1:0]  r2r_r, r2r_s;
    logic [N_REQ-1:0]  done_r, done_s;
    logic [WIDTH-1:0]  result_code_r, result_code_s;
    logic [15:0]       result_mv_r, result_mv_s;
    logic              under_r, under_s;
    logic              over_r, over_s;

    assign comp_sync_s = sync_r[SYNC_STAGES-1];
    assign tag_code_s  = code_pipe_r[SYNC_STAGES-1];

    // Comparator synchronizer with a matching ladder-code pipeline so each sample keeps its code.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                code_pipe_r[i] <= '0;
            end
        end else begin
            sync_r         <= {sync_r[SYNC_STAGES-2:0], bus.vcompare_raw};
            code_pipe_r[0] <= r2r_r;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                code_pipe_r[i] <= code_pipe_r[i-1];
            end
        end
    end

    // Round-robin pick: asserted request with the lowest rank counted from last_granted+1.
    always_comb begin
        int  rank;
        int  best;
        logic take;
        rank       = 0;
        best       = N_REQ;
        take       = 1'b0;
        pick_idx_s = '0;
        for (int j = 0; j < N_REQ; j++) begin
            rank       = (j + N_REQ - int'(last_granted_r) - 1) % N_REQ;
            take       = bus.req[j] && (rank < best);
            best       = take ? rank : best;
            pick_idx_s = take ? LG_W'(j) : pick_idx_s;
        end
    end

    // Next-state and next-output logic for the conversion sequencer.
    always_comb begin
        state_s        = state_r;
        step_cnt_s     = step_cnt_r;
        prev_s         = prev_r;
        last_granted_s = last_granted_r;
        grant_idx_s    = grant_idx_r;
        grant_s        = grant_r;
        r2r_s          = r2r_r;
        done_s         = '0;
        result_code_s  = result_code_r;
        under_s        = under_r;
        over_s         = over_r;
        edge_s         = prev_r & ~comp_sync_s;

        case (state_r)
            IDLE: begin
                r2r_s = '0;
                if (bus.enable && (|bus.req)) begin
                    state_s     = SETTLE;
                    grant_idx_s = pick_idx_s;
                    grant_s     = N_REQ'(1'b1) << pick_idx_s;
                    step_cnt_s  = '0;
                end else begin
                    grant_s = '0;
                end
            end
            SETTLE: begin
                if (step_cnt_r == STEP_LAST) begin
                    step_cnt_s = '0;
                    if (comp_sync_s) begin
                        state_s = RAMP;
                        r2r_s   = WIDTH'(1'b1);
                        prev_s  = 1'b1;
                    end else begin
                        state_s       = DONE;
                        r2r_s         = '0;
                        done_s        = grant_r;
                        result_code_s = '0;
                        under_s       = 1'b1;
                        over_s        = 1'b0;
                    end
                end else begin
                    step_cnt_s = step_cnt_r + CNT_W'(1'b1);
                end
            end
            RAMP: begin
                prev_s = comp_sync_s;
                // A falling edge wins even when the full-scale step expires in the same cycle.
                if (edge_s) begin
                    state_s       = DONE;
                    r2r_s         = '0;
                    done_s        = grant_r;
                    result_code_s = tag_code_s;
                    under_s       = 1'b0;
                    over_s        = 1'b0;
                end else if (step_cnt_r == STEP_LAST) begin
                    step_cnt_s = '0;
                    if (r2r_r == CODE_MAX) begin
                        state_s       = DONE;
                        r2r_s         = '0;
                        done_s        = grant_r;
                        result_code_s = CODE_MAX;
                        under_s       = 1'b0;
                        over_s        = 1'b1;
                    end else begin
                        r2r_s = r2r_r + WIDTH'(1'b1);
                    end
                end else begin
                    step_cnt_s = step_cnt_r + CNT_W'(1'b1);
                end
            end
            DONE: begin
                state_s        = IDLE;
                r2r_s          = '0;
                grant_s        = '0;
                last_granted_s = grant_idx_r;
            end
            default: begin
                state_s = IDLE;
                r2r_s   = '0;
                grant_s = '0;
            end
        endcase

        result_mv_s = code_to_mv(result_code_s);
        busy_s      = (state_s != IDLE);
    end

    // State and registered-output update.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= IDLE;
            step_cnt_r     <= '0;
            prev_r         <= 1'b0;
            last_granted_r <= LG_W'(N_REQ - 1);
            grant_idx_r    <= '0;
            grant_r        <= '0;
            busy_r         <= 1'b0;
            r2r_r          <= '0;
            done_r         <= '0;
            result_code_r  <= '0;
            result_mv_r    <= 16'd0;
            under_r        <= 1'b0;
            over_r         <= 1'b0;
        end else begin
            state_r        <= state_s;
            step_cnt_r     <= step_cnt_s;
            prev_r         <= prev_s;
            last_granted_r <= last_granted_s;
            grant_idx_r    <= grant_idx_s;
            grant_r        <= grant_s;
            busy_r         <= busy_s;
            r2r_r          <= r2r_s;
            done_r         <= done_s;
            result_code_r  <= result_code_s;
            result_mv_r    <= result_mv_s;
            under_r        <= under_s;
            over_r         <= over_s;
        end
    end

    assign bus.grant       = grant_r;
    assign bus.busy        = busy_r;
    assign bus.r2r_out     = r2r_r;
    assign bus.done        = done_r;
    assign bus.result_code = result_code_r;
    assign bus.result_mV   = result_mv_r;
    assign bus.under_range = under_r;
    assign bus.over_range  = over_r;
endmodule

// File: tb/tb_r2r_adc_scheduler.sv
// Directed bench for r2r_adc_scheduler: ideal comparator (r2r_out < vin_code), STEP_CYCLES=4.
module tb_r2r_adc_scheduler;
    localparam int WIDTH = 8;
    localparam int N_REQ = 2;
    localparam int STEP  = 4;
    localparam int SYNC  = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] vin_code;
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc;
    int         gbad;
    int         gbad_total;
    logic [1:0] seen;
    logic [1:0] exp_g;

    r2r_adc_scheduler_if #(.WIDTH(WIDTH), .N_REQ(N_REQ)) bus ();

    r2r_adc_scheduler #(
        .WIDTH(WIDTH), .N_REQ(N_REQ), .STEP_CYCLES(STEP), .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    assign bus.vcompare_raw = ({1'b0, bus.r2r_out} < vin_code);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Steps until done pulses or the budget runs out; strict demands grant==exp every cycle.
    task automatic wait_done(input int max_cycles, input logic [1:0] exp_grant, input bit strict,
                             output int cycles, output logic [1:0] seen_done, output int grant_bad);
        cycles    = 0;
        grant_bad = 0;
        while (bus.done === 2'b00 && cycles < max_cycles) begin
            step();
            cycles++;
            if (strict ? (bus.grant !== exp_grant)
                       : (bus.grant !== 2'b00 && bus.grant !== exp_grant))
                grant_bad++;
        end
        seen_done = bus.done;
    endtask

    initial begin
        reset      = 1'b1;
        bus.enable = 1'b0;
        bus.req    = 2'b00;
        vin_code   = 9'd100;
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("rst_grant", bus.grant, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_r2r", bus.r2r_out, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_code", bus.result_code, 0);
        chk("rst_mv", bus.result_mV, 0);
        chk("rst_flags", {bus.under_range, bus.over_range}, 0);

        // Mid-scale conversion, vin=100
        bus.enable = 1'b1;
        bus.req    = 2'b01;
        step();
        chk("t1_grant", bus.grant, 2'b01);
        chk("t1_busy", bus.busy, 1);
        wait_done(600, 2'b01, 1'b1, cyc, seen, gbad);
        chk("t1_done", seen, 2'b01);
        chk("t1_cycles", cyc, 403);
        chk("t1_grant_held", gbad, 0);
        chk("t1_code", bus.result_code, 100);
        chk("t1_mv", bus.result_mV, 1289);
        chk("t1_flags", {bus.under_range, bus.over_range}, 0);
        chk("t1_r2r_done", bus.r2r_out, 0);
        bus.req = 2'b00;
        step();
        chk("t1_done_drop", bus.done, 0);
        chk("t1_grant_drop", bus.grant, 0);
        chk("t1_idle", bus.busy, 0);

        // Under-range, vin=0
        vin_code = 9'd0;
        bus.req  = 2'b01;
        step();
        wait_done(20, 2'b01, 1'b1, cyc, seen, gbad);
        chk("t2_done", seen, 2'b01);
        chk("t2_cycles", cyc, 4);
        chk("t2_code", bus.result_code, 0);
        chk("t2_mv", bus.result_mV, 0);
        chk("t2_flags", {bus.under_range, bus.over_range}, 2'b10);
        bus.req = 2'b00;
        step();

        // Over-range, vin above full scale
        vin_code = 9'd256;
        bus.req  = 2'b01;
        step();
        wait_done(1100, 2'b01, 1'b1, cyc, seen, gbad);
        chk("t3_done", seen, 2'b01);
        chk("t3_cycles", cyc, 1024);
        chk("t3_code", bus.result_code, 255);
        chk("t3_mv", bus.result_mV, 3287);
        chk("t3_flags", {bus.under_range, bus.over_range}, 2'b01);
        bus.req = 2'b00;
        step();

        // Fair alternation from a fresh reset with both requesting
        reset = 1'b1;
        step();
        step();
        reset      = 1'b0;
        vin_code   = 9'd5;
        bus.req    = 2'b11;
        gbad_total = 0;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            wait_done(60, exp_g, 1'b0, cyc, seen, gbad);
            gbad_total += gbad;
            chk("t4_done", seen, exp_g);
            chk("t4_grant", bus.grant, exp_g);
            chk("t4_code", bus.result_code, 5);
            step();
            chk("t4_idle_busy", bus.busy, 0);
            chk("t4_idle_grant", bus.grant, 0);
        end
        chk("t4_grant_onehot", gbad_total, 0);
        bus.req = 2'b00;
        step();

        // Reset in the middle of the ramp
        vin_code = 9'd200;
        bus.req  = 2'b01;
        step();
        chk("t5_grant", bus.grant, 2'b01);
        cyc = 0;
        while (bus.r2r_out !== 8'd50 && cyc < 400) begin
            step();
            cyc++;
        end
        chk("t5_reach50", bus.r2r_out, 50);
        reset = 1'b1;
        step();
        chk("t5_rst_grant", bus.grant, 0);
        chk("t5_rst_busy", bus.busy, 0);
        chk("t5_rst_r2r", bus.r2r_out, 0);
        chk("t5_rst_done", bus.done, 0);
        chk("t5_rst_code", bus.result_code, 0);
        reset   = 1'b0;
        bus.req = 2'b10;
        step();
        chk("t5_grant1", bus.grant, 2'b10);
        wait_done(1000, 2'b10, 1'b1, cyc, seen, gbad);
        chk("t5_done", seen, 2'b10);
        chk("t5_cycles", cyc, 803);
        chk("t5_grant_held", gbad, 0);
        chk("t5_code", bus.result_code, 200);
        chk("t5_mv", bus.result_mV, 2578);
        chk("t5_flags", {bus.under_range, bus.over_range}, 0);
        bus.req = 2'b00;
        step();

        // enable gating
        vin_code   = 9'd20;
        bus.enable = 1'b0;
        bus.req    = 2'b01;
        repeat (3) step();
        chk("t6_no_grant", bus.grant, 0);
        chk("t6_no_busy", bus.busy, 0);
        bus.enable = 1'b1;
        step();
        chk("t6_grant", bus.grant, 2'b01);
        cyc = 0;
        while (bus.r2r_out !== 8'd10 && cyc < 100) begin
            step();
            cyc++;
        end
        chk("t6_reach10", bus.r2r_out, 10);
        bus.enable = 1'b0;
        wait_done(200, 2'b01, 1'b1, cyc, seen, gbad);
        chk("t6_done", seen, 2'b01);
        chk("t6_grant_held", gbad, 0);
        chk("t6_code", bus.result_code, 20);
        chk("t6_mv", bus.result_mV, 257);
        repeat (3) step();
        chk("t6_blocked_grant", bus.grant, 0);
        chk("t6_blocked_busy", bus.busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
